// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types for the pipeline hazard controller: forwarding selects and
// the data-memory wait FSM state encoding.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    WAIT = 2'b01,
    ERR  = 2'b10
  } dmem_state_e;

  localparam int DEF_REGW        = 5;
  localparam int DEF_MEM_TIMEOUT = 16;

endpackage

// File: rtl/pipe_hazard_ctrl_dmem_wait_fsm.sv
// Data-memory access sequencer: holds dmem_req until ack, counts wait cycles
// and latches a sticky error when the ack never arrives.
module dmem_wait_fsm
  import pipe_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = DEF_MEM_TIMEOUT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        memop_i,
  input  logic        dmem_ack_i,
  output logic        memstall_o,
  output logic        dmem_req_o,
  output logic        mem_err_o,
  output dmem_state_e state_o
);

  localparam int CNTW = $clog2(MEM_TIMEOUT + 1);
  localparam logic [CNTW-1:0] CNT_MAX = CNTW'(MEM_TIMEOUT);
  localparam logic [CNTW-1:0] CNT_ONE = CNTW'(1);

  dmem_state_e     state_q, state_d;
  logic [CNTW-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Stall is combinational so an ack releases the pipe in the cycle it arrives.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    memstall_o = 1'b0;
    dmem_req_o = 1'b0;
    case (state_q)
      IDLE: begin
        dmem_req_o = memop_i;
        if (memop_i && !dmem_ack_i) begin
          memstall_o = 1'b1;
          cnt_d      = CNT_ONE;
          state_d    = WAIT;
        end
      end
      WAIT: begin
        dmem_req_o = 1'b1;
        if (dmem_ack_i) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          memstall_o = 1'b1;
          if (cnt_q == CNT_MAX) begin
            state_d = ERR;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
      end
      ERR: begin
        memstall_o = 1'b1;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign mem_err_o = (state_q == ERR);
  assign state_o   = state_q;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard controller for the 5-stage pipeline: forwarding selects, load-use and
// branch stalls, flushes, and the memory-wait freeze merged into stage controls.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int REGW        = DEF_REGW,
  parameter int MEM_TIMEOUT = DEF_MEM_TIMEOUT
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [REGW-1:0] rs_D,
  input  logic [REGW-1:0] rt_D,
  input  logic [REGW-1:0] rs_E,
  input  logic [REGW-1:0] rt_E,
  input  logic [REGW-1:0] writereg_E,
  input  logic [REGW-1:0] writereg_M,
  input  logic [REGW-1:0] writereg_W,
  input  logic            regwrite_E,
  input  logic            regwrite_M,
  input  logic            regwrite_W,
  input  logic            memtoreg_E,
  input  logic            memtoreg_M,
  input  logic            memwrite_M,
  input  logic            branch_D,
  input  logic            pcsrc_D,
  input  logic            dmem_ack,
  output logic [1:0]      forwarda_E,
  output logic [1:0]      forwardb_E,
  output logic            forwarda_D,
  output logic            forwardb_D,
  output logic            stall_F,
  output logic            stall_D,
  output logic            stall_E,
  output logic            stall_M,
  output logic            flush_D,
  output logic            flush_E,
  output logic            flush_W,
  output logic            dmem_req,
  output logic            mem_err,
  output dmem_state_e     dbg_mem_state
);

  fwd_sel_e    fwd_a, fwd_b;
  logic        fwd_a_d, fwd_b_d;
  logic        lwstall, brstall, memop_m;
  logic        memstall, fsm_req, fsm_err;
  logic        front_stall;
  dmem_state_e fsm_state;

  // M-stage result is newer than W, so it wins when both match.
  always_comb begin
    fwd_a = FWD_RF;
    if (rs_E != '0 && rs_E == writereg_M && regwrite_M) begin
      fwd_a = FWD_MEM;
    end else if (rs_E != '0 && rs_E == writereg_W && regwrite_W) begin
      fwd_a = FWD_WB;
    end
  end

  always_comb begin
    fwd_b = FWD_RF;
    if (rt_E != '0 && rt_E == writereg_M && regwrite_M) begin
      fwd_b = FWD_MEM;
    end else if (rt_E != '0 && rt_E == writereg_W && regwrite_W) begin
      fwd_b = FWD_WB;
    end
  end

  assign fwd_a_d = (rs_D != '0) && (rs_D == writereg_M) && regwrite_M;
  assign fwd_b_d = (rt_D != '0) && (rt_D == writereg_M) && regwrite_M;

  assign lwstall = memtoreg_E && ((rt_E == rs_D) || (rt_E == rt_D));
  assign brstall = branch_D &&
                   ((regwrite_E && ((writereg_E == rs_D) || (writereg_E == rt_D))) ||
                    (memtoreg_M && ((writereg_M == rs_D) || (writereg_M == rt_D))));
  assign memop_m = memtoreg_M | memwrite_M;

  dmem_wait_fsm #(
    .MEM_TIMEOUT(MEM_TIMEOUT)
  ) u_dmem_wait_fsm (
    .clk        (clk),
    .reset      (reset),
    .memop_i    (memop_m),
    .dmem_ack_i (dmem_ack),
    .memstall_o (memstall),
    .dmem_req_o (fsm_req),
    .mem_err_o  (fsm_err),
    .state_o    (fsm_state)
  );

  assign front_stall = memstall | lwstall | brstall;

  // Every output is forced low while reset is asserted, including comb paths.
  always_comb begin
    forwarda_E    = reset ? 2'b00 : fwd_a;
    forwardb_E    = reset ? 2'b00 : fwd_b;
    forwarda_D    = !reset && fwd_a_d;
    forwardb_D    = !reset && fwd_b_d;
    stall_F       = !reset && front_stall;
    stall_D       = !reset && front_stall;
    stall_E       = !reset && memstall;
    stall_M       = !reset && memstall;
    flush_W       = !reset && memstall;
    flush_E       = !reset && (lwstall | brstall) && !memstall;
    flush_D       = !reset && pcsrc_D && !front_stall;
    dmem_req      = !reset && fsm_req;
    mem_err       = !reset && fsm_err;
    dbg_mem_state = reset ? IDLE : fsm_state;
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl with a short memory timeout; expected
// output vectors go through a queue and are compared with immediate assertions.
module tb_pipe_hazard_ctrl;

  localparam int REGW = 5;
  localparam int W    = 17;
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_ERR  = 2'd2;

  logic            clk;
  logic            reset;
  logic [REGW-1:0] rs_D, rt_D, rs_E, rt_E;
  logic [REGW-1:0] writereg_E, writereg_M, writereg_W;
  logic            regwrite_E, regwrite_M, regwrite_W;
  logic            memtoreg_E, memtoreg_M, memwrite_M;
  logic            branch_D, pcsrc_D, dmem_ack;
  logic [1:0]      forwarda_E, forwardb_E;
  logic            forwarda_D, forwardb_D;
  logic            stall_F, stall_D, stall_E, stall_M;
  logic            flush_D, flush_E, flush_W;
  logic            dmem_req, mem_err;
  logic [1:0]      dbg_mem_state;

  logic [W-1:0] exp_q[$];
  int           errors;
  int           checks;
  int unsigned  r, rb;

  pipe_hazard_ctrl #(
    .REGW       (REGW),
    .MEM_TIMEOUT(4)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .rs_D         (rs_D),
    .rt_D         (rt_D),
    .rs_E         (rs_E),
    .rt_E         (rt_E),
    .writereg_E   (writereg_E),
    .writereg_M   (writereg_M),
    .writereg_W   (writereg_W),
    .regwrite_E   (regwrite_E),
    .regwrite_M   (regwrite_M),
    .regwrite_W   (regwrite_W),
    .memtoreg_E   (memtoreg_E),
    .memtoreg_M   (memtoreg_M),
    .memwrite_M   (memwrite_M),
    .branch_D     (branch_D),
    .pcsrc_D      (pcsrc_D),
    .dmem_ack     (dmem_ack),
    .forwarda_E   (forwarda_E),
    .forwardb_E   (forwardb_E),
    .forwarda_D   (forwarda_D),
    .forwardb_D   (forwardb_D),
    .stall_F      (stall_F),
    .stall_D      (stall_D),
    .stall_E      (stall_E),
    .stall_M      (stall_M),
    .flush_D      (flush_D),
    .flush_E      (flush_E),
    .flush_W      (flush_W),
    .dmem_req     (dmem_req),
    .mem_err      (mem_err),
    .dbg_mem_state(dbg_mem_state)
  );

  // Clock and run-time guard.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "bench timed out");
  end

  task automatic clr();
    rs_D = '0; rt_D = '0; rs_E = '0; rt_E = '0;
    writereg_E = '0; writereg_M = '0; writereg_W = '0;
    regwrite_E = 1'b0; regwrite_M = 1'b0; regwrite_W = 1'b0;
    memtoreg_E = 1'b0; memtoreg_M = 1'b0; memwrite_M = 1'b0;
    branch_D = 1'b0; pcsrc_D = 1'b0; dmem_ack = 1'b0;
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  // stl = {F,D,E,M}, fl = {D,E,W}
  task automatic chk(input string tag, input logic [1:0] fa_e, input logic [1:0] fb_e,
                     input logic fa_d, input logic fb_d, input logic [3:0] stl,
                     input logic [2:0] fl, input logic req, input logic err,
                     input logic [1:0] st);
    logic [W-1:0] exp_v, act_v;
    exp_q.push_back({fa_e, fb_e, fa_d, fb_d, stl, fl, req, err, st});
    #1;
    act_v = {forwarda_E, forwardb_E, forwarda_D, forwardb_D, stall_F, stall_D,
             stall_E, stall_M, flush_D, flush_E, flush_W, dmem_req, mem_err, dbg_mem_state};
    exp_v = exp_q.pop_front();
    checks++;
    assert (act_v === exp_v) else begin
      errors++;
      $error("FAIL %s: observed=%b expected=%b", tag, act_v, exp_v);
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    reset  = 1'b1;
    clr();
    r  = $urandom_range(1, 31);
    rb = (r == 31) ? 1 : r + 1;

    // Reset forces everything low even with hazards present on the inputs.
    step();
    memtoreg_M = 1'b1; pcsrc_D = 1'b1; rs_E = 5'd3; writereg_M = 5'd3;
    regwrite_M = 1'b1; rs_D = 5'd3; memtoreg_E = 1'b1; rt_E = 5'd3;
    chk("reset_all_zero", 2'b00, 2'b00, 0, 0, 4'b0000, 3'b000, 0, 0, S_IDLE);
    step(); reset = 1'b0; clr();
    chk("idle_after_reset", 2'b00, 2'b00, 0, 0, 4'b0000, 3'b000, 0, 0, S_IDLE);

    // Forwarding.
    step(); clr();
    rs_E = 5'(r); writereg_M = 5'(r); regwrite_M = 1'b1; writereg_W = 5'(r); regwrite_W = 1'b1;
    chk("fwd_a_mem_prio", 2'b10, 2'b00, 0, 0, 4'b0000, 3'b000, 0, 0, S_IDLE);
    step(); writereg_M = 5'(rb); rt_E = 5'(rb);
    chk("fwd_a_wb_b_mem", 2'b01, 2'b10, 0, 0, 4'b0000, 3'b000, 0, 0, S_IDLE);
    step(); clr(); regwrite_M = 1'b1; regwrite_W = 1'b1;
    chk("fwd_zero_reg", 2'b00, 2'b00, 0, 0, 4'b0000, 3'b000, 0, 0, S_IDLE);
    step(); clr(); rs_D = 5'd7; rt_D = 5'd6; writereg_M = 5'd7; regwrite_M = 1'b1;
    chk("fwd_d_a", 2'b00, 2'b00, 1, 0, 4'b0000, 3'b000, 0, 0, S_IDLE);
    step(); regwrite_M = 1'b0;
    chk("fwd_d_no_regwrite", 2'b00, 2'b00, 0, 0, 4'b0000, 3'b000, 0, 0, S_IDLE);
    step(); clr(); rt_D = 5'd7; writereg_M = 5'd7; regwrite_M = 1'b1;
    chk("fwd_d_b", 2'b00, 2'b00, 0, 1, 4'b0000, 3'b000, 0, 0, S_IDLE);

    // Load-use stall.
    step(); clr(); memtoreg_E = 1'b1; rt_E = 5'd2; rs_D = 5'd2; rt_D = 5'd9;
    chk("lwstall_rs", 2'b00, 2'b00, 0, 0, 4'b1100, 3'b010, 0, 0, S_IDLE);
    step(); clr();
    chk("lwstall_release", 2'b00, 2'b00, 0, 0, 4'b0000, 3'b000, 0, 0, S_IDLE);
    step(); memtoreg_E = 1'b1; rt_E = 5'd2; rs_D = 5'd1; rt_D = 5'd2;
    chk("lwstall_rt", 2'b00, 2'b00, 0, 0, 4'b1100, 3'b010, 0, 0, S_IDLE);

    // Branch stalls and taken-branch flush.
    step(); clr(); branch_D = 1'b1; rs_D = 5'd4; rt_D = 5'd8;
    writereg_E = 5'd4; regwrite_E = 1'b1; pcsrc_D = 1'b1;
    chk("brstall_exe", 2'b00, 2'b00, 0, 0, 4'b1100, 3'b010, 0, 0, S_IDLE);
    step(); clr(); branch_D = 1'b1; rs_D = 5'd4; rt_D = 5'd8;
    memtoreg_M = 1'b1; writereg_M = 5'd8; dmem_ack = 1'b1;
    chk("brstall_load_m", 2'b00, 2'b00, 0, 0, 4'b1100, 3'b010, 1, 0, S_IDLE);
    step(); clr(); branch_D = 1'b1; pcsrc_D = 1'b1; rs_D = 5'd4; writereg_E = 5'd4;
    chk("branch_taken_flush", 2'b00, 2'b00, 0, 0, 4'b0000, 3'b100, 0, 0, S_IDLE);

    // Memory: zero-wait, then three stalled cycles released by ack.
    step(); clr(); memtoreg_M = 1'b1; dmem_ack = 1'b1;
    chk("mem_zero_wait", 2'b00, 2'b00, 0, 0, 4'b0000, 3'b000, 1, 0, S_IDLE);
    step(); clr(); memwrite_M = 1'b1;
    chk("mem_wait_1", 2'b00, 2'b00, 0, 0, 4'b1111, 3'b001, 1, 0, S_IDLE);
    step();
    chk("mem_wait_2", 2'b00, 2'b00, 0, 0, 4'b1111, 3'b001, 1, 0, S_WAIT);
    step(); memtoreg_E = 1'b1; rt_E = 5'd2; rs_D = 5'd2; pcsrc_D = 1'b1;
    chk("mem_wait_3_lw", 2'b00, 2'b00, 0, 0, 4'b1111, 3'b001, 1, 0, S_WAIT);
    step(); clr(); memwrite_M = 1'b1; dmem_ack = 1'b1;
    chk("mem_ack_release", 2'b00, 2'b00, 0, 0, 4'b0000, 3'b000, 1, 0, S_WAIT);
    step(); clr();
    chk("mem_back_idle", 2'b00, 2'b00, 0, 0, 4'b0000, 3'b000, 0, 0, S_IDLE);

    // Timeout into ERR, sticky until reset.
    step(); memtoreg_M = 1'b1;
    chk("timeout_start", 2'b00, 2'b00, 0, 0, 4'b1111, 3'b001, 1, 0, S_IDLE);
    for (int i = 1; i <= 4; i++) begin
      step();
      chk("timeout_wait", 2'b00, 2'b00, 0, 0, 4'b1111, 3'b001, 1, 0, S_WAIT);
    end
    step(); clr();
    chk("err_state", 2'b00, 2'b00, 0, 0, 4'b1111, 3'b001, 0, 1, S_ERR);
    step(); memtoreg_M = 1'b1; dmem_ack = 1'b1;
    chk("err_sticky", 2'b00, 2'b00, 0, 0, 4'b1111, 3'b001, 0, 1, S_ERR);
    step(); reset = 1'b1;
    chk("reset_from_err", 2'b00, 2'b00, 0, 0, 4'b0000, 3'b000, 0, 0, S_IDLE);
    step(); reset = 1'b0; clr();
    chk("err_cleared", 2'b00, 2'b00, 0, 0, 4'b0000, 3'b000, 0, 0, S_IDLE);

    // Reset in the middle of a wait.
    step(); memtoreg_M = 1'b1;
    chk("wait_start", 2'b00, 2'b00, 0, 0, 4'b1111, 3'b001, 1, 0, S_IDLE);
    step();
    chk("wait_before_reset", 2'b00, 2'b00, 0, 0, 4'b1111, 3'b001, 1, 0, S_WAIT);
    step(); reset = 1'b1;
    chk("reset_in_wait", 2'b00, 2'b00, 0, 0, 4'b0000, 3'b000, 0, 0, S_IDLE);
    step(); reset = 1'b0; memtoreg_M = 1'b0;
    chk("req_drop_after_reset", 2'b00, 2'b00, 0, 0, 4'b0000, 3'b000, 0, 0, S_IDLE);

    // Ack arriving on the timeout-compare cycle returns to IDLE.
    step(); memtoreg_M = 1'b1;
    chk("late_start", 2'b00, 2'b00, 0, 0, 4'b1111, 3'b001, 1, 0, S_IDLE);
    for (int i = 1; i <= 3; i++) begin
      step();
      chk("late_wait", 2'b00, 2'b00, 0, 0, 4'b1111, 3'b001, 1, 0, S_WAIT);
    end
    step(); dmem_ack = 1'b1;
    chk("ack_at_timeout", 2'b00, 2'b00, 0, 0, 4'b0000, 3'b000, 1, 0, S_WAIT);
    step(); clr();
    chk("idle_after_late_ack", 2'b00, 2'b00, 0, 0, 4'b0000, 3'b000, 0, 0, S_IDLE);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
